popcnt_seq: RTL
===============

// Module: popcnt_seq
// PURPOSE
//  Multi-cycle population-count unit for the ALU's wide-operand popcount op.
//  Sequences a single 8-bit weight counter (popcnt8_slice) over successive byte
//  slices of a DATA_W operand, accumulating the total bit count.
//  Sits between the ALU issue stage (valid/ready in) and writeback (valid/ready out).
// PARAMETERS
//  DATA_W   32   operand width; must be a multiple of 8, range 8..64
//  SLICES   DATA_W/8 (localparam)   byte slices per operand
//  CNT_W    $clog2(DATA_W+1) (localparam)   result width (32 -> 6)
// PORTS
//  clk        in   1        single clock, rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  in_valid   in   1        operand offered
//  in_ready   out  1        unit can accept an operand this cycle
//  in_data    in   DATA_W   operand
//  out_valid  out  1        result valid, held until taken
//  out_ready  in   1        consumer takes result
//  out_count  out  CNT_W    number of 1 bits in the operand
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, out_valid=0, out_count=0, acc=0,
//   shift reg=0, slice idx=0; in_ready=1 once rst_n=1. Takes effect mid-RUN too;
//   the in-flight operand is discarded.
//  FSM: IDLE -> RUN -> DONE.
//   IDLE: in_ready=1. On in_valid: load shift reg<=in_data, acc<=0, idx<=0; go RUN.
//   RUN: in_ready=0. Each cycle: acc<=acc+zext(popcnt8(sh[7:0])); sh<=sh>>8; idx++.
//     Last slice (idx==SLICES-1): out_count<=final acc, out_valid<=1; go DONE.
//   DONE: out_valid=1, out_count stable. in_ready = out_ready.
//     out_ready & in_valid: result retires and new operand loads the same edge; go RUN.
//     out_ready & !in_valid: out_valid<=0; go IDLE.
//     !out_ready: hold everything; in_valid ignored.
//  Latency: operand accepted at edge k -> out_valid high after edge k+SLICES.
//   Throughput: one op per SLICES+1 cycles with out_ready tied 1.
//  Arithmetic: slice count 4 bits (0..8), zero-extended to CNT_W. No overflow:
//   max acc = DATA_W, which fits CNT_W.
//  out_count changes only on the edge that raises out_valid. Between ops it keeps
//   the last value (0 after reset).
//  in_data is sampled only on the accept edge. It may change freely afterwards.
// CONFIGURATION
//  POPCNT_EARLY_EXIT_EN defined: in RUN, if (sh>>8)==0 after the current slice,
//   that slice is treated as last and the FSM goes to DONE.
//   Latency becomes 1..SLICES cycles (set by the highest nonzero byte).
//   An operand of 0 completes in 1 cycle.
//  Undefined: always exactly SLICES RUN cycles, regardless of data.
//  Result values are identical in both builds.
// STRUCTURE
//  Shared package popcnt_pkg:
//   - state encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2
//   - SLICE_W=8, SLICE_CNT_W=4
//  Sub-module popcnt8_slice: combinational 8-bit -> 4-bit weight counter.
//   One instance, fed by sh[7:0].
//  Remaining logic lives in popcnt_seq: FSM, idx counter, shift reg, accumulator.
// TESTING  (DATA_W=32 unless noted)
//  1 Reset: rst_n=0 -> out_valid=0, out_count=0. After release, in_ready=1.
//  2 Full ones: in_data=32'hFFFF_FFFF, out_ready=1 -> out_count=32,
//    out_valid rises 4 cycles after accept.
//  3 Edge bits: 32'h8000_0001 -> out_count=2 in 4 cycles, both builds.
//  4 Early exit: 32'h0000_00F0 -> 4 after 1 cycle with POPCNT_EARLY_EXIT_EN;
//    after 4 cycles without. 32'h0 -> 0 after 1 cycle with the macro.
//  5 Backpressure: out_ready=0 for 5 cycles -> out_valid and out_count held,
//    in_ready=0. Then out_ready=1 with in_valid=1, in_data=32'h0000_000F
//    -> accepted the same edge; next out_count=4.
//  6 Reset mid-op: rst_n pulsed low during RUN -> out_valid=0 immediately.
//    Then 32'h1234_5678 -> out_count=13.
//  Random: 2000 operands with random valid/ready vs. a $countones model, both builds.

Source files
------------

// File: rtl/popcnt_pkg.sv
// Shared definitions for the sequential popcount unit: FSM encoding and slice sizing.
package popcnt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SLICE_W     = 8;
  localparam int SLICE_CNT_W = 4;

endpackage

// File: rtl/popcnt8_slice.sv
// Combinational 8-bit weight counter; one instance is time-shared across the
// byte slices of the operand by popcnt_seq.
module popcnt8_slice
  import popcnt_pkg::*;
(
  input  logic [SLICE_W-1:0]     data_i,
  output logic [SLICE_CNT_W-1:0] count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < SLICE_W; i++) begin
      count_o = count_o + SLICE_CNT_W'(data_i[i]);
    end
  end

endmodule

// File: rtl/popcnt_seq.sv
// Multi-cycle population count over byte slices of a DATA_W operand.
// Optional feature: define POPCNT_EARLY_EXIT_EN to finish once the remaining bytes are all zero.
module popcnt_seq
  import popcnt_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(DATA_W+1)-1:0] out_count,
  output logic [1:0]                  dbg_state_o
);

  localparam int SLICES = DATA_W / SLICE_W;
  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; out_valid stays high with out_count stable until out_ready.
  state_t              state_q, state_d;
  logic [DATA_W-1:0]   sh_q, sh_d;
  logic [CNT_W-1:0]    acc_q, acc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                valid_q, valid_d;

  logic [SLICE_CNT_W-1:0] slice_cnt;
  logic [CNT_W-1:0]       acc_sum;
  logic [DATA_W-1:0]      sh_next;
  logic                   last_slice;

  popcnt8_slice u_slice (
    .data_i  (sh_q[SLICE_W-1:0]),
    .count_o (slice_cnt)
  );

  assign acc_sum = acc_q + CNT_W'(slice_cnt);
  assign sh_next = sh_q >> SLICE_W;

`ifdef POPCNT_EARLY_EXIT_EN
  assign last_slice = (idx_q == IDX_W'(SLICES - 1)) || (sh_next == '0);
`else
  assign last_slice = (idx_q == IDX_W'(SLICES - 1));
`endif

  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    count_d  = count_q;
    valid_d  = valid_q;
    in_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sh_d    = in_data;
          acc_d   = '0;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_sum;
        sh_d  = sh_next;
        idx_d = idx_q + IDX_W'(1);
        if (last_slice) begin
          count_d = acc_sum;
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        in_ready = out_ready;
        // Retiring a result and accepting the next operand share one edge.
        if (out_ready) begin
          valid_d = 1'b0;
          if (in_valid) begin
            sh_d    = in_data;
            acc_d   = '0;
            idx_d   = '0;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_count   = count_q;
  assign dbg_state_o = state_q;

endmodule
